// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limit and the 1-bit full-adder reference function.
package full_adder_pkg;
  localparam int FA_MAX_WIDTH = 64;
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign {cout, s} = fa_bit(a, b, cin);
endmodule

// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder, one-cycle latency; FULL_ADDER_OVF_EN adds a signed-overflow output.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (.a(a[i]), .b(b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= c[WIDTH];
      end
    end
  end
`ifdef FULL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else if (in_valid) ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for a 1-bit and an 8-bit full_adder instance.
module tb_full_adder;
  import full_adder_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
  logic v8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ov1, s1, co1, ov8, co8;
  logic [7:0] s8;
  logic of1, of8;
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] q1[$];
  logic [9:0] q8[$];

  always #5 clk = ~clk;

`ifdef FULL_ADDER_OVF_EN
  full_adder #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
                              .out_valid(ov1), .s(s1), .cout(co1), .ovf(of1));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
                              .out_valid(ov8), .s(s8), .cout(co8), .ovf(of8));
`else
  full_adder #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
                              .out_valid(ov1), .s(s1), .cout(co1));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .in_valid(v8), .a(a8), .b(b8), .cin(ci8),
                              .out_valid(ov8), .s(s8), .cout(co8));
  assign of1 = 1'b0;
  assign of8 = 1'b0;
`endif

  // Chains fa_bit over w bits; returns {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci, input int w);
    logic [7:0] sm = '0;
    logic c = ci, cp = ci;
    logic [1:0] r;
    for (int i = 0; i < w; i++) begin
      r = fa_bit(x[i], y[i], c);
      sm[i] = r[0];
      cp = c;
      c = r[1];
    end
    return {cp ^ c, c, sm};
  endfunction

  task automatic drive8(input logic v, input logic [7:0] x, input logic [7:0] y, input logic ci);
    v8 = v; a8 = x; b8 = y; ci8 = ci;
    if (v && !reset) q8.push_back(model(x, y, ci, 8));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({ov1, s1, co1} !== 3'b000) begin n_bad++; $display("FAIL reset_w1 got=%b want=000", {ov1, s1, co1}); end
    n_cmp++;
    if ({ov8, s8, co8} !== 10'd0) begin n_bad++; $display("FAIL reset_w8 got=%h want=000", {ov8, s8, co8}); end
`ifdef FULL_ADDER_OVF_EN
    n_cmp++;
    if ({of1, of8} !== 2'b00) begin n_bad++; $display("FAIL reset_ovf got=%b want=00", {of1, of8}); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_exhaustive;
    logic [1:0] tab [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    logic [2:0] e;
    logic [2:0] iv;
    logic [9:0] m;
    for (int i = 0; i < 8; i++) begin
      iv = 3'(i);
      v1 = 1'b1; a1 = iv[2]; b1 = iv[1]; ci1 = iv[0];
      m = model({7'd0, a1}, {7'd0, b1}, ci1, 1);
      q1.push_back({m[9], m[8], m[0]});
      tick();
      e = q1.pop_front();
      n_cmp++;
      if (ov1 !== 1'b1 || {s1, co1} !== tab[i])
        begin n_bad++; $display("FAIL exh_tab%0d got v=%b s/c=%b want v=1 s/c=%b", i, ov1, {s1, co1}, tab[i]); end
      n_cmp++;
      if ({co1, s1} !== e[1:0]) begin n_bad++; $display("FAIL exh_model%0d got=%b want=%b", i, {co1, s1}, e[1:0]); end
`ifdef FULL_ADDER_OVF_EN
      n_cmp++;
      if (of1 !== e[2]) begin n_bad++; $display("FAIL exh_ovf%0d got=%b want=%b", i, of1, e[2]); end
`endif
    end
    v1 = 1'b0;
  endtask

  task automatic test_wrap;
    logic [9:0] e;
    drive8(1'b1, 8'hFF, 8'h00, 1'b1);
    tick();
    e = q8.pop_front();
    n_cmp++;
    if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'h00}) begin n_bad++; $display("FAIL wrap_ff_00 got v=%b c=%b s=%h want v=1 c=1 s=00", ov8, co8, s8); end
    n_cmp++;
    if ({co8, s8} !== e[8:0]) begin n_bad++; $display("FAIL wrap_ff_00_model got=%h want=%h", {co8, s8}, e[8:0]); end
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    e = q8.pop_front();
    n_cmp++;
    if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'hFF}) begin n_bad++; $display("FAIL wrap_ff_ff got v=%b c=%b s=%h want v=1 c=1 s=ff", ov8, co8, s8); end
    drive8(1'b0, 8'hxx, 8'hzz, 1'bx);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ov8, co8, s8} !== {1'b0, 1'b1, 8'hFF}) begin n_bad++; $display("FAIL hold%0d got v=%b c=%b s=%h want v=0 c=1 s=ff", i, ov8, co8, s8); end
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] e;
    reset = 1'b1;
    drive8(1'b1, 8'h55, 8'h55, 1'b0);
    tick();
    n_cmp++;
    if ({ov8, co8, s8} !== 10'd0) begin n_bad++; $display("FAIL reset_mid got v=%b c=%b s=%h want all 0", ov8, co8, s8); end
    reset = 1'b0;
    drive8(1'b1, 8'h01, 8'h02, 1'b0);
    tick();
    e = q8.pop_front();
    n_cmp++;
    if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'h03}) begin n_bad++; $display("FAIL after_reset got v=%b c=%b s=%h want v=1 c=0 s=03", ov8, co8, s8); end
    n_cmp++;
    if (q8.size() !== 0) begin n_bad++; $display("FAIL sb_empty got=%0d want=0", q8.size()); end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
  endtask

`ifdef FULL_ADDER_OVF_EN
  task automatic test_ovf;
    logic [9:0] e;
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    e = q8.pop_front();
    n_cmp++;
    if ({of8, co8, s8} !== {1'b1, 1'b0, 8'h80}) begin n_bad++; $display("FAIL ovf_7f got o=%b c=%b s=%h want o=1 c=0 s=80", of8, co8, s8); end
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    e = q8.pop_front();
    n_cmp++;
    if ({of8, co8, s8} !== {1'b1, 1'b1, 8'h00}) begin n_bad++; $display("FAIL ovf_80 got o=%b c=%b s=%h want o=1 c=1 s=00", of8, co8, s8); end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
  endtask
`endif

  task automatic test_back_to_back;
    logic [9:0] e;
    int bad_before = n_bad;
    for (int i = 0; i < 1000; i++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
      e = q8.pop_front();
      n_cmp++;
`ifdef FULL_ADDER_OVF_EN
      if (ov8 !== 1'b1 || {of8, co8, s8} !== e)
`else
      if (ov8 !== 1'b1 || {co8, s8} !== e[8:0])
`endif
      begin
        n_bad++;
        if (n_bad - bad_before < 10)
          $display("FAIL b2b%0d got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h", i, ov8, of8, co8, s8, e[9], e[8], e[7:0]);
      end
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (ov8 !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got v=%b want v=0", ov8); end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_wrap();
    test_reset_mid();
`ifdef FULL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
